seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector. It is the successor to the fixed 101 Mealy non-overlapping detector.
- Pattern value, pattern length (1..PATTERN_W) and overlap mode are runtime-programmable.
- Adds an input qualifier, a registered match copy and a saturating match counter.
- Sits on a serial bit stream; match feeds downstream framing/interrupt logic.
- Reset configuration (101, length 3, non-overlapping) reproduces the legacy detector exactly.

Parameters:
PATTERN_W, 8, maximum pattern length in bits (>=2)
CNT_W, 16, match counter width
RST_PATTERN, 8'b0000_0101, pattern value loaded at reset (low RST_LEN bits used)
RST_LEN, 3, pattern length loaded at reset
RST_OVERLAP, 0, overlap mode loaded at reset (0 = non-overlapping)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle
cfg_pattern  input  PATTERN_W  pattern; bit [len-1] is the first bit received
cfg_len  input  $clog2(PATTERN_W+1)  active pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
cnt_clr  input  1  clear match_count
match  output  1  Mealy match, combinational from current in_bit
match_q  output  1  match registered one cycle
match_count  output  CNT_W  saturating count of matches

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - pattern = RST_PATTERN, len = RST_LEN, overlap = RST_OVERLAP.
  - History shift register = 0, fill = 0.
  - match = 0, match_q = 0, match_count = 0.
- Length clamp: cfg_len = 0 is stored as 1; cfg_len > PATTERN_W is stored as PATTERN_W.
- State:
  - hist[PATTERN_W-1:0] holds the last accepted bits, newest in bit 0.
  - fill counts accepted bits toward a match and saturates at len.
- Matching:
  - cand = {hist[PATTERN_W-2:0], in_bit}.
  - match = in_valid & ~cfg_load & ~rst & (fill >= len-1) & (cand[len-1:0] == pattern[len-1:0]).
  - The pure Mealy path has zero latency: match is valid in the same cycle as the final bit.
- On an accepted bit (in_valid & ~cfg_load):
  - hist <= cand.
  - If match & ~overlap: fill <= 0, so the next match needs len fresh bits.
  - Otherwise: fill <= min(fill+1, len).
- When in_valid = 0: hist, fill and match are unchanged or low as applicable; match = 0.
- match_q <= match every cycle; it is 0 on the cycle after reset.
- match_count:
  - Increments on match and saturates at all-ones.
  - When cnt_clr and match occur in the same cycle, cnt_clr wins and the count becomes 0.
- cfg_load:
  - Takes priority over in_valid; the concurrent bit is discarded and match = 0.
  - Sets pattern/len/overlap and clears hist and fill.
  - match_count is not cleared.
- rst mid-stream: reset has priority over everything; partial history is lost and the configuration returns to the RST_* values.
- Overlap mode change: only via cfg_load, so mode never changes with partial history.
- len = 1: every valid bit equal to pattern[0] matches, in either overlap mode.

Decomposition:
- Shared package seq_det_pkg:
  - Default constants DEF_PATTERN_W, DEF_CNT_W.
  - Length-clamp function.
  - Typedef for cfg struct {pattern, len, overlap}.
- One natural sub-module: sat_counter (CNT_W, inc, clr, saturating), reusable elsewhere. Everything else stays in one module.

Test Plan:
- Reset config, non-overlap, bits 1,0,1,0,1 -> match high only on bit 3; match_count = 1; match_q high one cycle later.
- cfg_load pattern 101, len 3, overlap = 1, bits 1,0,1,0,1 -> match on bits 3 and 5; match_count = 2.
- cfg_load pattern 8'b1101_0110, len 8, overlap = 0, stream 1,1,0,1,0,1,1,0,1,1,0,1,0,1,1,0 -> matches on bits 8 and 16; in_valid low gaps inserted mid-pattern do not break a match.
- cfg_load asserted concurrently with a would-be final bit -> match = 0; history cleared; a following 1,0,1 matches on its 3rd bit.
- CNT_W = 2, overlap, len 1, pattern 1, six consecutive 1s -> match_count reaches 3 and holds; cnt_clr with a match in the same cycle gives 0.
- rst pulsed after bits 1,0 of 101, then 1 -> no match; config returns to 101/3/non-overlap; clamp check: cfg_len 0 behaves as 1, cfg_len 15 behaves as 8.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
//   DEF_PATTERN_W / DEF_CNT_W : default maximum pattern length and match counter width
//   DEF_LEN_W                 : width of a pattern-length field for the default build
//   cfg_t                     : {pattern, len, overlap} for the default build
//   clamp_len()               : maps a requested length into 1..max_len
package seq_det_pkg;

  localparam int unsigned DEF_PATTERN_W = 8;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_LEN_W     = $clog2(DEF_PATTERN_W + 1);

  typedef struct packed {
    logic [DEF_PATTERN_W-1:0] pattern;
    logic [DEF_LEN_W-1:0]     len;
    logic                     overlap;
  } cfg_t;

  // A zero length would match on every cycle without consuming a bit, so it becomes 1.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, count -> 0
//   inc_i   : count up by one unless already all-ones
//   clr_i   : clear to zero; wins over inc_i
//   count_o : current count
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector (Mealy).
//   clk_i / rst_i    : clock, synchronous active-high reset
//   cfg_load_i       : load cfg_pattern_i / cfg_len_i / cfg_overlap_i; drops any concurrent bit
//   cfg_pattern_i    : pattern, bit [len-1] is the first bit received
//   cfg_len_i        : active length, clamped into 1..PATTERN_W
//   cfg_overlap_i    : 1 = overlapping detection, 0 = non-overlapping
//   in_valid_i       : in_bit_i carries a bit this cycle
//   in_bit_i         : serial data
//   cnt_clr_i        : clear match_count_o (wins over a concurrent match)
//   match_o          : combinational match on the final bit
//   match_q_o        : match_o delayed one cycle
//   match_count_o    : saturating number of matches
// Reset configuration (101, length 3, non-overlapping) behaves as the legacy fixed detector.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          PATTERN_W   = DEF_PATTERN_W,
  parameter int unsigned          CNT_W       = DEF_CNT_W,
  parameter logic [PATTERN_W-1:0] RST_PATTERN = PATTERN_W'(8'b0000_0101),
  parameter int unsigned          RST_LEN     = 3,
  parameter bit                   RST_OVERLAP = 1'b0,
  localparam int unsigned         LEN_W       = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_load_i,
  input  logic [PATTERN_W-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]     cfg_len_i,
  input  logic                 cfg_overlap_i,
  input  logic                 in_valid_i,
  input  logic                 in_bit_i,
  input  logic                 cnt_clr_i,
  output logic                 match_o,
  output logic                 match_q_o,
  output logic [CNT_W-1:0]     match_count_o
);

  typedef struct packed {
    logic [PATTERN_W-1:0] pattern;
    logic [LEN_W-1:0]     len;
    logic                 overlap;
  } cfg_w_t;

  localparam cfg_w_t RstCfg = '{
    pattern: RST_PATTERN,
    len:     LEN_W'(clamp_len(RST_LEN, PATTERN_W)),
    overlap: RST_OVERLAP
  };

  cfg_w_t cfg_q, cfg_d;
  // Only the newest PATTERN_W-1 bits are kept; the oldest bit of a full-length window
  // is the incoming bit's predecessor chain and never needs storing beyond cand.
  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic                 match_q;

  logic [PATTERN_W-1:0] cand;
  logic [PATTERN_W-1:0] len_mask;
  logic                 accept;
  logic                 fill_ok;
  logic                 pat_eq;
  logic                 match;

  assign accept = in_valid_i & ~cfg_load_i;
  assign cand   = {hist_q, in_bit_i};

  // When len == PATTERN_W the shift wraps to zero and the subtraction yields all-ones.
  assign len_mask = (PATTERN_W'(1) << cfg_q.len) - PATTERN_W'(1);
  assign fill_ok  = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, cfg_q.len};
  assign pat_eq   = ((cand ^ cfg_q.pattern) & len_mask) == '0;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q   <= RstCfg;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match;
    end
  end

  // Next state
  always_comb begin
    cfg_d  = cfg_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load_i) begin
      cfg_d.pattern = cfg_pattern_i;
      cfg_d.len     = LEN_W'(clamp_len(32'(cfg_len_i), PATTERN_W));
      cfg_d.overlap = cfg_overlap_i;
      hist_d        = '0;
      fill_d        = '0;
    end else if (in_valid_i) begin
      hist_d = cand[PATTERN_W-2:0];
      if (match && !cfg_q.overlap) begin
        // Non-overlapping: the next match must be built from len fresh bits.
        fill_d = '0;
      end else if (fill_q != cfg_q.len) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    match     = accept & ~rst_i & fill_ok & pat_eq;
    match_o   = match;
    match_q_o = match_q;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (match),
    .clr_i   (cnt_clr_i),
    .count_o (match_count_o)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: table-driven vectors plus hand-written corner sequences.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_seq_detector_param;

  typedef struct packed {
    logic       vld;
    logic       b;
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       clr;
    logic       exp;
  } vec_t;

  typedef struct packed {
    logic        m;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        in_valid;
  logic        in_bit;
  logic        cnt_clr;
  logic        match, match_q;
  logic [15:0] match_count;
  logic        match_c2, match_q_c2;
  logic [1:0]  match_count_c2;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  sb_t         sb_q[$];
  vec_t        tbl[$];

  seq_detector_param dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .in_valid_i    (in_valid),
    .in_bit_i      (in_bit),
    .cnt_clr_i     (cnt_clr),
    .match_o       (match),
    .match_q_o     (match_q),
    .match_count_o (match_count)
  );

  seq_detector_param #(
    .CNT_W (2)
  ) dut_c2 (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .cfg_len_i     (cfg_len),
    .cfg_overlap_i (cfg_overlap),
    .in_valid_i    (in_valid),
    .in_bit_i      (in_bit),
    .cnt_clr_i     (cnt_clr),
    .match_o       (match_c2),
    .match_q_o     (match_q_c2),
    .match_count_o (match_count_c2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t bit_v(input logic b, input logic e);
    vec_t v = '0;
    v.vld = 1'b1;
    v.b   = b;
    v.exp = e;
    return v;
  endfunction

  function automatic vec_t gap_v();
    vec_t v = '0;
    return v;
  endfunction

  function automatic vec_t load_v(input logic [7:0] p, input logic [3:0] l, input logic o);
    vec_t v = '0;
    v.load = 1'b1;
    v.pat  = p;
    v.len  = l;
    v.ov   = o;
    return v;
  endfunction

  function automatic vec_t clr_v(input logic vld, input logic b, input logic e);
    vec_t v = '0;
    v.vld = vld;
    v.b   = b;
    v.clr = 1'b1;
    v.exp = e;
    return v;
  endfunction

  // Bits and expected matches given MSB-first, i.e. bits[n-1] is sent first.
  task automatic add_stream(input logic [15:0] bits, input logic [15:0] exps, input int n);
    for (int i = n - 1; i >= 0; i--) tbl.push_back(bit_v(bits[i], exps[i]));
  endtask

  // One cycle: drive, check the Mealy output mid-cycle, queue the registered expectations,
  // then compare them after the edge.
  task automatic apply(input vec_t v, input string name);
    sb_t e;
    in_valid    = v.vld;
    in_bit      = v.b;
    cfg_load    = v.load;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ov;
    cnt_clr     = v.clr;
    @(negedge clk);
    check({name, " match"}, 16'(match), 16'(v.exp));
    check({name, " match_c2"}, 16'(match_c2), 16'(v.exp));
    if (v.clr) begin
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else if (v.exp) begin
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      if (exp_cnt2 != 2'b11) exp_cnt2 = exp_cnt2 + 2'd1;
    end
    e.m    = v.exp;
    e.cnt  = exp_cnt;
    e.cnt2 = exp_cnt2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, " match_q"}, 16'(match_q), 16'(e.m));
      check({name, " count"}, match_count, e.cnt);
      check({name, " count_c2"}, 16'(match_count_c2), 16'(e.cnt2));
    end
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    exp_cnt  = '0;
    exp_cnt2 = '0;
    sb_q.delete();
  endtask

  initial begin
    vec_t v;
    rst         = 1'b1;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    cnt_clr     = 1'b0;
    exp_cnt     = '0;
    exp_cnt2    = '0;
    repeat (2) @(posedge clk);
    do_reset();
    check("reset match", 16'(match), 16'd0);
    check("reset match_q", 16'(match_q), 16'd0);
    check("reset count", match_count, 16'd0);
    check("reset count_c2", 16'(match_count_c2), 16'd0);

    // Reset configuration: 101, length 3, non-overlapping.
    add_stream(16'b10101, 16'b00100, 5);
    run_tbl("legacy");

    // Overlapping 101.
    tbl.push_back(load_v(8'h05, 4'd3, 1'b1));
    add_stream(16'b10101, 16'b00101, 5);
    run_tbl("overlap");

    // Full-width pattern with idle gaps inside it.
    tbl.push_back(load_v(8'hD6, 4'd8, 1'b0));
    add_stream(16'b1101, 16'b0000, 4);
    tbl.push_back(gap_v());
    tbl.push_back(gap_v());
    add_stream(16'b0110, 16'b0001, 4);
    add_stream(16'b1101, 16'b0000, 4);
    tbl.push_back(gap_v());
    add_stream(16'b0110, 16'b0001, 4);
    run_tbl("len8");

    // cfg_load on a would-be final bit discards the bit.
    apply(load_v(8'h05, 4'd3, 1'b0), "ldc cfg");
    apply(bit_v(1'b1, 1'b0), "ldc b1");
    apply(bit_v(1'b0, 1'b0), "ldc b2");
    v     = load_v(8'h05, 4'd3, 1'b0);
    v.vld = 1'b1;
    v.b   = 1'b1;
    apply(v, "ldc concurrent");
    apply(bit_v(1'b1, 1'b0), "ldc n1");
    apply(bit_v(1'b0, 1'b0), "ldc n2");
    apply(bit_v(1'b1, 1'b1), "ldc n3");

    // len 1: every 1 matches; the 2-bit counter saturates; clear beats a match.
    tbl.push_back(clr_v(1'b0, 1'b0, 1'b0));
    tbl.push_back(load_v(8'h01, 4'd1, 1'b1));
    add_stream(16'b111111, 16'b111111, 6);
    tbl.push_back(clr_v(1'b1, 1'b1, 1'b1));
    add_stream(16'b0, 16'b0, 1);
    tbl.push_back(load_v(8'h01, 4'd1, 1'b0));
    add_stream(16'b1101, 16'b1101, 4);
    run_tbl("len1");

    // Reset mid-stream loses history and restores 101/3/non-overlap.
    apply(load_v(8'h05, 4'd3, 1'b1), "rst cfg");
    apply(bit_v(1'b1, 1'b0), "rst b1");
    apply(bit_v(1'b0, 1'b0), "rst b2");
    do_reset();
    check("rst match_q", 16'(match_q), 16'd0);
    check("rst count", match_count, 16'd0);
    add_stream(16'b10101, 16'b00100, 5);
    run_tbl("post_rst");

    // Length clamps: 0 acts as 1, 15 acts as 8.
    tbl.push_back(load_v(8'h01, 4'd0, 1'b1));
    add_stream(16'b101, 16'b101, 3);
    tbl.push_back(load_v(8'hA5, 4'd15, 1'b0));
    add_stream(16'b10100101, 16'b00000001, 8);
    run_tbl("clamp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
